// File: rtl/pulse_sync_stretch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pulse_sync_stretch_pkg
// Brief    : Edge-mode encodings and edge selection helper.
// Revision : 1.0 - initial release
// ============================================================================
package pulse_sync_stretch_pkg;

    `include "pulse_sync_stretch_defs.vh"

    function automatic logic edge_select(
        input logic [1:0] mode,
        input logic       rise,
        input logic       fall
    );
        logic sel;
        sel = 1'b0;
        case (mode)
            EDGE_RISE: sel = rise;
            EDGE_FALL: sel = fall;
            EDGE_BOTH: sel = rise | fall;
            default:   sel = 1'b0;
        endcase
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_sync_stretch_ch.sv
`default_nettype none
// ============================================================================
// Module   : pulse_sync_stretch_ch
// Brief    : One channel: synchroniser, edge select, hold-off, stretch, missed.
// Revision : 1.0 - initial release
// ============================================================================
module pulse_sync_stretch_ch
    import pulse_sync_stretch_pkg::*;
#(
    parameter int SYNC_STAGES = 3,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_armed,
    input  logic                 i_async,
    input  logic [1:0]           i_edge_mode,
    input  logic [CNT_WIDTH-1:0] i_holdoff,
    input  logic [CNT_WIDTH-1:0] i_stretch,
    input  logic                 i_missed_clr,
    output logic                 o_pulse,
    output logic                 o_stretch,
    output logic                 o_busy,
    output logic [CNT_WIDTH-1:0] o_missed
);

    localparam logic [CNT_WIDTH-1:0] c_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_MAX = '1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_pulse;
    logic [CNT_WIDTH-1:0]   r_holdoff_cnt;
    logic [CNT_WIDTH-1:0]   r_stretch_cnt;
    logic [CNT_WIDTH-1:0]   r_missed;

    logic                   w_sy;
    logic                   w_event;
    logic                   w_accept;
    logic                   w_reject;
    logic [CNT_WIDTH-1:0]   w_stretch_load;

    assign w_sy           = r_sync[SYNC_STAGES-1];
    assign w_event        = i_armed & edge_select(i_edge_mode, w_sy & ~r_prev, ~w_sy & r_prev);
    assign w_accept       = w_event & (r_holdoff_cnt == '0);
    assign w_reject       = w_event & (r_holdoff_cnt != '0);
    assign w_stretch_load = (i_stretch == '0) ? c_ONE : i_stretch;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync        <= '0;
            r_prev        <= 1'b0;
            r_pulse       <= 1'b0;
            r_holdoff_cnt <= '0;
            r_stretch_cnt <= '0;
            r_missed      <= '0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev  <= w_sy;
            r_pulse <= w_accept;

            // A rejected event lets the running hold-off keep counting down.
            if (w_accept) begin
                r_holdoff_cnt <= i_holdoff;
            end else if (r_holdoff_cnt != '0) begin
                r_holdoff_cnt <= r_holdoff_cnt - c_ONE;
            end

            if (w_accept) begin
                r_stretch_cnt <= w_stretch_load;
            end else if (r_stretch_cnt != '0) begin
                r_stretch_cnt <= r_stretch_cnt - c_ONE;
            end

            // A clear coinciding with a rejection keeps that one event.
            if (i_missed_clr) begin
                r_missed <= w_reject ? c_ONE : '0;
            end else if (w_reject && (r_missed != c_MAX)) begin
                r_missed <= r_missed + c_ONE;
            end
        end
    end

    assign o_pulse   = r_pulse;
    assign o_stretch = (r_stretch_cnt != '0);
    assign o_busy    = (r_holdoff_cnt != '0);
    assign o_missed  = r_missed;

endmodule
`default_nettype wire

// File: rtl/pulse_sync_stretch_defs.vh
// EDGE_MODE encodings shared by every file of the pulse_sync_stretch block.
`ifndef PULSE_SYNC_STRETCH_DEFS_VH
`define PULSE_SYNC_STRETCH_DEFS_VH
localparam logic [1:0] EDGE_RISE = 2'b00;
localparam logic [1:0] EDGE_FALL = 2'b01;
localparam logic [1:0] EDGE_BOTH = 2'b10;
localparam logic [1:0] EDGE_OFF  = 2'b11;
`endif

// File: rtl/pulse_sync_stretch.sv
`default_nettype none
// ============================================================================
// Module   : pulse_sync_stretch
// Brief    : Multi-channel event synchroniser with hold-off and stretching.
// Revision : 1.0 - initial release
// ============================================================================
module pulse_sync_stretch
    import pulse_sync_stretch_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 3,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic [CHANNELS-1:0]           ASYNC_IN,
    input  logic [2*CHANNELS-1:0]         EDGE_MODE,
    input  logic [CNT_WIDTH-1:0]          HOLDOFF,
    input  logic [CNT_WIDTH-1:0]          STRETCH,
    input  logic                          MISSED_CLR,
    output logic [CHANNELS-1:0]           PULSE_OUT,
    output logic [CHANNELS-1:0]           STRETCH_OUT,
    output logic [CHANNELS-1:0]           BUSY,
    output logic [CHANNELS*CNT_WIDTH-1:0] MISSED_CNT
);

    localparam int                 c_ARM_W   = $clog2(SYNC_STAGES + 2);
    localparam logic [c_ARM_W-1:0] c_ARM_END = c_ARM_W'(SYNC_STAGES);
    localparam logic [c_ARM_W-1:0] c_ARM_ONE = c_ARM_W'(1);

    logic [c_ARM_W-1:0] r_arm_cnt;
    logic               r_armed;

    // Arms once the synchroniser history is filled, so stale levels never fire.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_arm_cnt <= '0;
            r_armed   <= 1'b0;
        end else if (!r_armed) begin
            r_arm_cnt <= r_arm_cnt + c_ARM_ONE;
            r_armed   <= (r_arm_cnt == c_ARM_END);
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        pulse_sync_stretch_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_WIDTH   (CNT_WIDTH)
        ) u_ch (
            .i_clk        (CLK),
            .i_rst_n      (RST_N),
            .i_armed      (r_armed),
            .i_async      (ASYNC_IN[c]),
            .i_edge_mode  (EDGE_MODE[2*c +: 2]),
            .i_holdoff    (HOLDOFF),
            .i_stretch    (STRETCH),
            .i_missed_clr (MISSED_CLR),
            .o_pulse      (PULSE_OUT[c]),
            .o_stretch    (STRETCH_OUT[c]),
            .o_busy       (BUSY[c]),
            .o_missed     (MISSED_CNT[c*CNT_WIDTH +: CNT_WIDTH])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_pulse_sync_stretch.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_sync_stretch
// Brief    : Directed self-checking bench for pulse_sync_stretch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_sync_stretch;

    logic        CLK;
    logic        RST_N;
    logic [3:0]  ASYNC_IN;
    logic [7:0]  EDGE_MODE;
    logic [7:0]  HOLDOFF;
    logic [7:0]  STRETCH;
    logic        MISSED_CLR;
    logic [3:0]  PULSE_OUT;
    logic [3:0]  STRETCH_OUT;
    logic [3:0]  BUSY;
    logic [31:0] MISSED_CNT;

    int total = 0;
    int bad   = 0;

    pulse_sync_stretch #(
        .CHANNELS    (4),
        .SYNC_STAGES (3),
        .CNT_WIDTH   (8)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .ASYNC_IN    (ASYNC_IN),
        .EDGE_MODE   (EDGE_MODE),
        .HOLDOFF     (HOLDOFF),
        .STRETCH     (STRETCH),
        .MISSED_CLR  (MISSED_CLR),
        .PULSE_OUT   (PULSE_OUT),
        .STRETCH_OUT (STRETCH_OUT),
        .BUSY        (BUSY),
        .MISSED_CNT  (MISSED_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        RST_N      = 1'b0;
        ASYNC_IN   = 4'b1000;
        EDGE_MODE  = 8'h00;
        HOLDOFF    = 8'd0;
        STRETCH    = 8'd1;
        MISSED_CLR = 1'b0;

        #12;
        chk("rst_pulse",   {28'b0, PULSE_OUT},   32'h0);
        chk("rst_stretch", {28'b0, STRETCH_OUT}, 32'h0);
        chk("rst_busy",    {28'b0, BUSY},        32'h0);
        chk("rst_missed",  MISSED_CNT,           32'h0);

        // Release reset with ch3 already high: no pulse during or after arming.
        tick();
        RST_N = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            chk("arm_quiet", {28'b0, PULSE_OUT}, 32'h0);
        end

        // Single rising edge on ch0: pulse exactly in the cycle after edge k+3.
        ASYNC_IN[0] = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk("ch0_pulse",   {28'b0, PULSE_OUT},   (c == 4) ? 32'h1 : 32'h0);
            chk("ch0_stretch", {28'b0, STRETCH_OUT}, (c == 4) ? 32'h1 : 32'h0);
        end

        // Hold-off 10 on ch1: accept, reject after 4 cycles, accept after 12.
        HOLDOFF = 8'd10;
        ASYNC_IN[1] = 1'b1; ticks(2); ASYNC_IN[1] = 1'b0; ticks(2);
        chk("ho_first_pulse", {28'b0, PULSE_OUT}, 32'h2);
        chk("ho_first_busy",  {28'b0, BUSY},      32'h2);
        ASYNC_IN[1] = 1'b1; ticks(2); ASYNC_IN[1] = 1'b0; ticks(2);
        chk("ho_rej_pulse",  {28'b0, PULSE_OUT}, 32'h0);
        chk("ho_rej_missed", MISSED_CNT,         32'h0000_0100);
        chk("ho_rej_busy",   {28'b0, BUSY},      32'h2);
        ticks(4);
        ASYNC_IN[1] = 1'b1;
        tick();
        chk("ho_busy_last", {28'b0, BUSY}, 32'h2);
        tick();
        chk("ho_busy_done", {28'b0, BUSY}, 32'h0);
        ASYNC_IN[1] = 1'b0;
        ticks(2);
        chk("ho_third_pulse", {28'b0, PULSE_OUT}, 32'h2);
        HOLDOFF = 8'd0;

        // Both-edge mode on ch2 with stretch 5 and 3-cycle toggles.
        STRETCH = 8'd5;
        EDGE_MODE[5:4] = 2'b10;
        ASYNC_IN[2] = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            tick();
            chk("both_pulse",   {31'b0, PULSE_OUT[2]},
                (c == 4 || c == 7 || c == 10) ? 32'h1 : 32'h0);
            chk("both_stretch", {31'b0, STRETCH_OUT[2]},
                (c >= 4 && c <= 14) ? 32'h1 : 32'h0);
            if (c == 3) ASYNC_IN[2] = 1'b0;
            if (c == 6) ASYNC_IN[2] = 1'b1;
        end
        STRETCH = 8'd1;

        // ch3 fall then rise gives one pulse; ch0 disabled never pulses.
        EDGE_MODE[1:0] = 2'b11;
        ASYNC_IN[3] = 1'b0;
        ASYNC_IN[0] = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            chk("ch3_pulse", {31'b0, PULSE_OUT[3]}, (c == 7) ? 32'h1 : 32'h0);
            chk("off_pulse", {31'b0, PULSE_OUT[0]}, 32'h0);
            if (c == 3) begin
                ASYNC_IN[3] = 1'b1;
                ASYNC_IN[0] = 1'b1;
            end
        end
        chk("off_missed", {24'b0, MISSED_CNT[7:0]}, 32'h0);

        // Saturation: HOLDOFF=255, toggle ch0 in both-edge mode for ~350 events.
        HOLDOFF = 8'd255;
        EDGE_MODE[1:0] = 2'b10;
        for (int i = 0; i < 350; i++) begin
            ASYNC_IN[0] = ~ASYNC_IN[0];
            ticks(2);
        end
        ticks(4);
        chk("sat_missed0", {24'b0, MISSED_CNT[7:0]},  32'd255);
        chk("sat_missed1", {24'b0, MISSED_CNT[15:8]}, 32'd1);

        for (int w = 0; w < 300 && BUSY[0]; w++) tick();
        chk("sat_drain", {31'b0, BUSY[0]}, 32'h0);

        ASYNC_IN[0] = ~ASYNC_IN[0]; ticks(2);
        ASYNC_IN[0] = ~ASYNC_IN[0]; ticks(2);
        chk("clr_accept", {31'b0, PULSE_OUT[0]}, 32'h1);
        tick();
        MISSED_CLR = 1'b1;
        tick();
        MISSED_CLR = 1'b0;
        chk("clr_coincident", {24'b0, MISSED_CNT[7:0]},  32'd1);
        chk("clr_other_ch",   {24'b0, MISSED_CNT[15:8]}, 32'd0);
        tick();
        MISSED_CLR = 1'b1;
        tick();
        MISSED_CLR = 1'b0;
        chk("clr_alone", MISSED_CNT, 32'h0);

        // Reset asserted mid-stretch drops outputs immediately, then re-arms.
        HOLDOFF = 8'd20;
        STRETCH = 8'd20;
        ASYNC_IN[1] = 1'b1;
        ticks(4);
        chk("pre_rst_pulse", {31'b0, PULSE_OUT[1]}, 32'h1);
        ticks(2);
        chk("pre_rst_stretch", {31'b0, STRETCH_OUT[1]}, 32'h1);
        chk("pre_rst_busy",    {31'b0, BUSY[1]},        32'h1);
        #3;
        RST_N = 1'b0;
        #1;
        chk("midrst_pulse",   {28'b0, PULSE_OUT},   32'h0);
        chk("midrst_stretch", {28'b0, STRETCH_OUT}, 32'h0);
        chk("midrst_busy",    {28'b0, BUSY},        32'h0);
        chk("midrst_missed",  MISSED_CNT,           32'h0);
        ticks(2);
        RST_N = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            chk("rearm_pulse",   {28'b0, PULSE_OUT},   32'h0);
            chk("rearm_stretch", {28'b0, STRETCH_OUT}, 32'h0);
            chk("rearm_busy",    {28'b0, BUSY},        32'h0);
        end
        ASYNC_IN[1] = 1'b0; ticks(2);
        ASYNC_IN[1] = 1'b1; ticks(4);
        chk("rearm_event", {28'b0, PULSE_OUT}, 32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
